mux41_scan_ctrl: RTL
====================

# mux41_scan_ctrl

Select sequencer that sits directly upstream of the structural 4:1 multiplexer. It drives the mux's `s0`/`s1` select lines through the enabled channels in ascending order, holding each channel for a programmable dwell. It takes the mux output `y` back in, captures one bit per channel into a 4-bit sample register, and signals completion with a one-cycle `done` pulse.

## Interface
- `DWELL_W`, default 4: width of the dwell input and of the internal dwell counter.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  scan request; sampled only in IDLE.
- `mask`  input  4  channel enables, bit i = mux input i; latched at start.
- `dwell`  input  DWELL_W  hold cycles per channel minus one; latched at start.
- `y_in`  input  1  mux output `y`, fed back.
- `s0`  output  1  mux select LSB.
- `s1`  output  1  mux select MSB.
- `busy`  output  1  high while a scan is in progress.
- `done`  output  1  one-cycle pulse at scan end.
- `sample`  output  4  captured `y_in` per channel.

## Operation
- States: IDLE and SCAN.
- IDLE: `{s1,s0}`=00, `busy`=0.
- `start`=1 with nonzero `mask` in IDLE: latch `mask` and `dwell`, select the lowest enabled channel, clear the dwell counter, go to SCAN, set `busy`=1.
- `start`=1 with `mask`=0000: stay in IDLE, pulse `done` for one cycle, `busy` stays 0, `sample` unchanged.
- SCAN:
  - The counter runs 0..latched dwell. The select is held for dwell+1 cycles.
  - On the edge that ends the hold, `y_in` is written into `sample[ch]` and the select advances to the next higher enabled channel. Disabled channels are skipped with zero cycles spent on them.
  - After the highest enabled channel's capture: go to IDLE, `busy`=0, `done`=1 for one cycle, select returns to 00.
- `sample` bits of disabled channels keep their previous value.
- `start` while `busy` is ignored. Changes to `mask`/`dwell` mid-scan have no effect.
- The dwell counter is DWELL_W bits unsigned and never wraps: it resets to 0 on each channel advance. `dwell`=0 gives a 1-cycle hold.
- Reset asserted mid-scan aborts the scan immediately, with no `done` pulse.

## Timing
- Reset values: `s0`=0, `s1`=0, `busy`=0, `done`=0, `sample`=0000, state IDLE, counter 0, latched mask 0.
- All outputs are registered. There is no combinational path from the inputs to the outputs.
- `start` is sampled at edge 0. From edge 0: `busy`=1 and the first select is driven.
- With N enabled channels, the scan occupies N*(dwell+1) cycles. `done` is high and `busy` low in the cycle after edge N*(dwell+1).
- `y_in` is assumed to settle within the same cycle as the select (combinational mux). It is sampled on the last hold edge.
- A new `start` is accepted in the cycle where `done` is high, because the state is already IDLE.

## Configuration
- `MUX41_SCAN_CONTINUOUS_EN` defined:
  - `start` is treated as a run level.
  - At each pass end, `done` pulses.
  - If `start`=1, the block wraps to the lowest enabled channel in the same edge, keeps `busy`=1, and re-latches `mask`/`dwell`. If the re-latched mask is 0000, it goes to IDLE.
  - If `start`=0, it goes to IDLE as in single-shot mode.
- Macro undefined: single-shot. One pass per `start`, and `start` held high re-triggers only from IDLE.

## Structure
- Package `mux41_scan_pkg`:
  - State enum (IDLE, SCAN).
  - Constants `NUM_CH`=4 and `SEL_W`=2.
- Sub-module `mux41_next_ch`: combinational priority finder. Given the mask and the current channel, it returns the next higher enabled channel and a `last` flag. The same finder, with "current" set to "none", gives the first channel.
- The 4:1 mux is instantiated outside this block. This block drives its select lines.

## Test plan
- Reset mid-idle and mid-scan -> all outputs 0, no `done`; the next `start` behaves normally.
- `mask`=1111, `dwell`=0, `y_in` = bit `{s1,s0}` of pattern 1010 -> selects 00,01,10,11 for one cycle each; `done` after edge 4; `sample`=1010.
- Preload `sample`=1111, `mask`=0101, `dwell`=2, pattern 0000 -> select 00 for 3 cycles, then 10 for 3 cycles; `done` after edge 6; `sample`=1010.
- `mask`=0000 -> `done` after edge 0, `busy` never 1, `select` stays 00.
- `start` pulsed at edge 2 during a scan with `mask`=1111, `dwell`=1 -> ignored, `done` after edge 8 only. A new `start` in the `done` cycle -> the scan restarts with `busy` after that edge.
- With `MUX41_SCAN_CONTINUOUS_EN`, `start` held, `mask`=1000, `dwell`=1 -> `s`=11 constant, `busy`=1, `done` after edges 2, 4, 6. Dropping `start` -> IDLE at the next pass end.

Source files
------------

// File: rtl/mux41_scan_ctrl_pkg.sv
// mux41_scan_pkg: shared types and constants for the 4:1 mux select sequencer.
//   state_e : scan FSM state (StIdle, StScan)
//   NUM_CH  : number of mux channels
//   SEL_W   : width of the mux select
package mux41_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        StIdle,
        StScan
    } state_e;

endpackage

// File: rtl/mux41_scan_ctrl_if.sv
// mux41_scan_ctrl_if: request/select/sample bundle between a scan requester and the
// mux41_scan_ctrl sequencer.
//   start, mask, dwell : scan request and its configuration (master -> slave)
//   y_in               : mux output fed back (master -> slave)
//   s0, s1             : mux select lines (slave -> master)
//   busy, done, sample : scan status and captured bits (slave -> master)
interface mux41_scan_ctrl_if
    import mux41_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
);
    logic              start;
    logic [NUM_CH-1:0] mask;
    logic [DWELL_W-1:0] dwell;
    logic              y_in;
    logic              s0;
    logic              s1;
    logic              busy;
    logic              done;
    logic [NUM_CH-1:0] sample;

    modport master (
        output start, mask, dwell, y_in,
        input  s0, s1, busy, done, sample
    );

    modport slave (
        input  start, mask, dwell, y_in,
        output s0, s1, busy, done, sample
    );
endinterface

// File: rtl/mux41_scan_ctrl_next_ch.sv
// mux41_next_ch: combinational priority finder for the scan sequencer.
//   mask      : channel enables
//   cur       : current channel
//   cur_valid : 0 means "no current channel", so the lowest enabled channel is returned
//   next_ch   : lowest enabled channel above cur (0 when none)
//   last      : no enabled channel above cur (with cur_valid=0: mask is empty)
module mux41_next_ch
    import mux41_scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              cur_valid,
    output logic [SEL_W-1:0]  next_ch,
    output logic              last
);

    always_comb begin
        next_ch = '0;
        last    = 1'b1;
        // Walk downwards so the lowest qualifying channel is the one left standing.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (!cur_valid || (i > int'(cur)))) begin
                next_ch = SEL_W'(i);
                last    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux41_scan_ctrl.sv
// mux41_scan_ctrl: drives the select lines of an external 4:1 mux through the enabled
// channels in ascending order, holding each for dwell+1 cycles, capturing the fed-back
// mux output into sample[ch] on the last hold edge, and pulsing done at scan end.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mux41_scan_ctrl_if.slave (start/mask/dwell/y_in in; s0/s1/busy/done/sample out)
// Build option: define MUX41_SCAN_CONTINUOUS_EN to treat start as a run level and wrap
// back to the first enabled channel at each pass end while start is high.
module mux41_scan_ctrl
    import mux41_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 4
)(
    input logic clk,
    input logic rst,
    mux41_scan_ctrl_if.slave bus
);

    state_e             state_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [SEL_W-1:0]   ch_q;
    logic               busy_q;
    logic               done_q;
    logic [NUM_CH-1:0]  sample_q;

    logic [SEL_W-1:0]   first_ch;
    logic               first_none;
    logic [SEL_W-1:0]   next_ch;
    logic               next_last;

    // First channel of the live request mask; first_none flags an empty mask.
    mux41_next_ch u_first (
        .mask      (bus.mask),
        .cur       ('0),
        .cur_valid (1'b0),
        .next_ch   (first_ch),
        .last      (first_none)
    );

    // Successor of the current channel within the latched mask.
    mux41_next_ch u_next (
        .mask      (mask_q),
        .cur       (ch_q),
        .cur_valid (1'b1),
        .next_ch   (next_ch),
        .last      (next_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            mask_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
            ch_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (first_none) begin
                            done_q <= 1'b1;
                        end else begin
                            mask_q  <= bus.mask;
                            dwell_q <= bus.dwell;
                            ch_q    <= first_ch;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    if (cnt_q == dwell_q) begin
                        sample_q[ch_q] <= bus.y_in;
                        cnt_q          <= '0;
                        if (!next_last) begin
                            ch_q <= next_ch;
                        end else begin
                            done_q <= 1'b1;
`ifdef MUX41_SCAN_CONTINUOUS_EN
                            if (bus.start && !first_none) begin
                                mask_q  <= bus.mask;
                                dwell_q <= bus.dwell;
                                ch_q    <= first_ch;
                            end else begin
                                ch_q    <= '0;
                                busy_q  <= 1'b0;
                                state_q <= StIdle;
                            end
`else
                            ch_q    <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.s0     = ch_q[0];
    assign bus.s1     = ch_q[1];
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sample = sample_q;

endmodule
